// File: rtl/led_blink.sv
// LED heartbeat: a clock-enable divider advances a 4-bit binary count on the
// four user LEDs. Everything runs in the clk_100MHz domain; no derived clocks.

// Free-running modulo-DIVISOR counter producing a one-cycle enable tick.
module clk_divider #(
  parameter int unsigned DIVISOR = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [W-1:0] LAST = W'(DIVISOR - 1);

  logic [W-1:0] cnt;

  // Count 0..DIVISOR-1 and wrap; reset clears the count immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  // Terminal-count decode; masked during reset so DIVISOR=1 (cnt pinned at
  // its terminal value) still produces no ticks while reset is held.
  always_comb begin
    tick = (cnt == LAST) && !rst;
  end

endmodule

// Top level: divider instance plus the LED counter it enables.
module led_blink #(
  parameter int unsigned CLK_DIVISOR = 50_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  output logic [3:0] led
);

  logic tick;

  clk_divider #(
    .DIVISOR(CLK_DIVISOR)
  ) clk_div (
    .clk (clk_100MHz),
    .rst (reset),
    .tick(tick)
  );

  // Advance the LED count once per tick, wrapping 4'hF -> 4'h0.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      led <= '0;
    end else if (tick) begin
      led <= led + 4'd1;
    end
  end

endmodule

// File: tb/tb_led_blink.sv
// Bench for led_blink: one instance at DIVISOR=5, one at DIVISOR=1, sharing
// clock and reset. A table of edge-count/expected-LED records drives the main
// timeline; hand-written sequences cover async reset and the DIVISOR=1 wrap.
module tb_led_blink;

  logic       clk;
  logic       reset;
  logic [3:0] led5;
  logic [3:0] led1;

  int n_cmp = 0;
  int n_bad = 0;

  led_blink #(.CLK_DIVISOR(5)) uut (
    .clk_100MHz(clk),
    .reset     (reset),
    .led       (led5)
  );

  led_blink #(.CLK_DIVISOR(1)) uut1 (
    .clk_100MHz(clk),
    .reset     (reset),
    .led       (led1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Bench model of the divider phase: rising edges since reset release, mod 5.
  int unsigned mphase = 0;
  always @(posedge clk) begin
    if (reset) mphase = 0;
    else       mphase = (mphase == 4) ? 0 : mphase + 1;
  end

  // Per-cycle monitor: tick pattern and single-step LED behaviour.
  logic [3:0] prev_led;
  logic       prev_tick;
  bit         have_prev = 0;
  always @(negedge clk) begin
    if (reset) begin
      have_prev = 0;
      check("tick_in_reset", {3'b000, uut.clk_div.tick}, 4'd0);
      check("tick1_in_reset", {3'b000, uut1.clk_div.tick}, 4'd0);
    end else begin
      check("tick_phase", {3'b000, uut.clk_div.tick}, {3'b000, (mphase == 4)});
      check("tick1_always", {3'b000, uut1.clk_div.tick}, 4'd1);
      if (have_prev)
        check("led_step", led5, prev_tick ? prev_led + 4'd1 : prev_led);
      prev_led  = led5;
      prev_tick = uut.clk_div.tick;
      have_prev = 1;
    end
  end

  typedef struct {
    int unsigned edge_n;   // rising edges since reset release
    logic [3:0]  exp_led;  // DIVISOR=5 instance
    logic [3:0]  exp_led1; // DIVISOR=1 instance
  } vec_t;

  vec_t vecs[10];
  int unsigned edges;

  initial begin
    vecs[0] = '{4,  4'd0,  4'd4};
    vecs[1] = '{5,  4'd1,  4'd5};   // 65 ns: first step
    vecs[2] = '{9,  4'd1,  4'd9};
    vecs[3] = '{10, 4'd2,  4'd10};
    vecs[4] = '{15, 4'd3,  4'd15};
    vecs[5] = '{16, 4'd3,  4'd0};
    vecs[6] = '{50, 4'd10, 4'd2};   // 515 ns: 1010
    vecs[7] = '{79, 4'd15, 4'd15};
    vecs[8] = '{80, 4'd0,  4'd0};   // 1111 -> 0000 wrap
    vecs[9] = '{85, 4'd1,  4'd5};

    reset = 1'b1;
    edges = 0;

    // Held in reset 0..20 ns.
    #7;  check("reset_led5_7ns",  led5, 4'd0); check("reset_led1_7ns",  led1, 4'd0);
    #5;  check("reset_led5_12ns", led5, 4'd0); check("reset_led1_12ns", led1, 4'd0);
    #7;  check("reset_led5_19ns", led5, 4'd0); check("reset_led1_19ns", led1, 4'd0);
    #1;  reset = 1'b0;  // 20 ns

    for (int i = 0; i < 10; i++) begin
      while (edges < vecs[i].edge_n) begin
        @(posedge clk);
        edges++;
      end
      #1;
      check($sformatf("vec%0d_led5", i), led5, vecs[i].exp_led);
      check($sformatf("vec%0d_led1", i), led1, vecs[i].exp_led1);
    end

    // Move to a point where the DIVISOR=5 count shows 0110.
    while (edges < 112) begin
      @(posedge clk);
      edges++;
    end
    #1;
    check("pre_reset_0110", led5, 4'b0110);

    // Async reset 3 ns after an edge, checked before the next edge.
    #2; reset = 1'b1;
    #1;
    check("async_clear_led5", led5, 4'd0);
    check("async_clear_led1", led1, 4'd0);
    @(posedge clk);
    #2;
    check("held_led5", led5, 4'd0);
    check("held_led1", led1, 4'd0);
    reset = 1'b0;

    @(posedge clk); #1;
    check("post_rel_e1_led5", led5, 4'd0);
    check("post_rel_e1_led1", led1, 4'd1);
    repeat (3) @(posedge clk);
    #1;
    check("post_rel_e4_led5", led5, 4'd0);
    check("post_rel_e4_led1", led1, 4'd4);
    @(posedge clk); #1;
    check("post_rel_e5_led5", led5, 4'd1);
    check("post_rel_e5_led1", led1, 4'd5);

    // DIVISOR=1 instance runs through 15 -> 0 -> 1, one step per edge.
    for (int unsigned k = 6; k <= 17; k++) begin
      @(posedge clk); #1;
      check($sformatf("div1_edge%0d", k), led1, 4'(k));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
